press_classify: RTL and testbench
=================================

PRESS_CLASSIFY -- requirements
Module: press_classify

Interface
REQ-001 Parameter CNT_W, default 16: width of the press-length and gap counters.
REQ-002 Parameter LONG_TH, default 1000: minimum press length in cycles classified as long; legal range 1..2^CNT_W-1.
REQ-003 Parameter DBL_GAP, default 300: maximum release-to-press gap in cycles for a double press; legal range 1..2^CNT_W-1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  synchronous enable; low forces IDLE and suppresses all event outputs.
REQ-007 rise  input  1  single-cycle pulse from the upstream edge detector, marking input going high (press).
REQ-008 down  input  1  single-cycle pulse from the upstream edge detector, marking input going low (release).
REQ-009 short_press  output  1  single-cycle pulse: isolated short press completed.
REQ-010 long_press  output  1  single-cycle pulse: press of length >= LONG_TH released.
REQ-011 double_press  output  1  single-cycle pulse: second press of a double press released.
REQ-012 press_len  output  CNT_W  length of the classified press; valid with any event pulse, held otherwise.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 proto_err  output  1  single-cycle pulse: unexpected input pulse ignored.

Function
REQ-015 FSM states: IDLE, PRESS1, GAP, PRESS2; event outputs and press_len are registered.
REQ-016 IDLE: rise -> PRESS1, len counter loaded with 1.
REQ-017 PRESS1/PRESS2: len counter increments by 1 per cycle, saturating at 2^CNT_W-1 (no wrap).
REQ-018 Press length definition: rise in cycle t, down in cycle t+N -> length N.
REQ-019 PRESS1 + down with len >= LONG_TH -> long_press = 1, press_len = len, next state IDLE.
REQ-020 PRESS1 + down with len < LONG_TH -> GAP, gap counter loaded with 1, no output.
REQ-021 GAP: gap counter increments per cycle; rise while gap counter <= DBL_GAP -> PRESS2, len counter loaded with 1.
REQ-022 GAP: gap counter == DBL_GAP and no rise -> short_press = 1, press_len = first-press length (held in a register), next state IDLE.
REQ-023 Rise and gap counter == DBL_GAP in the same cycle -> the rise wins (PRESS2); no short_press.
REQ-024 PRESS2 + down -> double_press = 1, press_len = second-press length, next state IDLE; LONG_TH is not checked.
REQ-025 Event latency: pulse asserted in the cycle immediately after the decisive input cycle; exactly one cycle wide.
REQ-026 At most one of short_press, long_press, double_press is high in any cycle.
REQ-027 Unexpected pulses produce proto_err = 1 the next cycle, with no state change: down in IDLE or GAP; rise in PRESS1 or PRESS2.
REQ-028 Simultaneous rise and down in any state: both ignored, proto_err = 1 the next cycle.
REQ-029 en low: next state IDLE, counters cleared, no event pulses or proto_err; press_len holds.
REQ-030 busy = (state != IDLE), derived directly from the state register.

Reset
REQ-031 rst_n low asynchronously sets: state IDLE, all counters 0, short_press/long_press/double_press/proto_err 0, press_len 0, busy 0.
REQ-032 Reset mid-press discards the press; after release of reset, the first down is treated per REQ-027 (proto_err).
REQ-033 On reset release, operation resumes on the first rising clk edge with rst_n high.

Verification (CNT_W=8, LONG_TH=8, DBL_GAP=4, en=1)
REQ-034 Short: rise@10, down@13 -> short_press@18, press_len=3; busy 0 from 18.
REQ-035 Long: rise@10, down@20 -> long_press@21, press_len=10; no short_press.
REQ-036 Double, gap boundary: rise@10, down@12, rise@16 (gap=4), down@19 -> double_press@20, press_len=3. Repeat with second rise@17 -> short_press@17, then the new press proceeds from IDLE.
REQ-037 Saturation: rise@10, down@310 -> long_press@311, press_len=255.
REQ-038 Errors/reset: rise+down@5 -> proto_err@6, state IDLE. rst_n low during PRESS1, then down after release -> proto_err, no events.

Source files
------------

// File: rtl/press_if.sv
// Button-press classifier bus.
//   master: drives en, rise, down; observes the classification results.
//   slave : consumes en, rise, down; drives short_press, long_press,
//           double_press, press_len, busy and proto_err.
interface press_if #(
  parameter int unsigned CNT_W = 16
);
  logic             en;
  logic             rise;
  logic             down;
  logic             short_press;
  logic             long_press;
  logic             double_press;
  logic [CNT_W-1:0] press_len;
  logic             busy;
  logic             proto_err;

  modport master (
    output en, rise, down,
    input  short_press, long_press, double_press, press_len, busy, proto_err
  );

  modport slave (
    input  en, rise, down,
    output short_press, long_press, double_press, press_len, busy, proto_err
  );
endinterface

// File: rtl/press_classify.sv
// Classifies presses from edge-detector pulses as short, long or double.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   bus (slave)     - en/rise/down in; registered single-cycle event pulses
//                     short_press/long_press/double_press/proto_err, press_len
//                     held with the last event, busy = FSM not idle.
module press_classify #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned LONG_TH = 1000,
  parameter int unsigned DBL_GAP = 300
) (
  input logic   clk,
  input logic   rst_n,
  press_if.slave bus
);

  localparam logic [CNT_W-1:0] LONG_V = CNT_W'(LONG_TH);
  localparam logic [CNT_W-1:0] GAP_V  = CNT_W'(DBL_GAP);
  localparam logic [CNT_W-1:0] MAX_V  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS1, GAP, PRESS2} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] len_q, len_nx;
  logic [CNT_W-1:0] gap_q, gap_nx;
  logic [CNT_W-1:0] len1_q, len1_nx;
  logic [CNT_W-1:0] plen_q, plen_nx;
  logic             short_q, short_nx;
  logic             long_q, long_nx;
  logic             dbl_q, dbl_nx;
  logic             perr_q, perr_nx;

  logic             rise_ok, down_ok, both;
  logic [CNT_W-1:0] len_inc, gap_inc;

  // A simultaneous rise and down is a protocol error and neither is honoured.
  assign rise_ok = bus.rise & ~bus.down;
  assign down_ok = bus.down & ~bus.rise;
  assign both    = bus.rise & bus.down;

  // Saturating increments.
  assign len_inc = (len_q == MAX_V) ? len_q : len_q + ONE_V;
  assign gap_inc = (gap_q == MAX_V) ? gap_q : gap_q + ONE_V;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      len_q   <= '0;
      gap_q   <= '0;
      len1_q  <= '0;
      plen_q  <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      len_q   <= len_nx;
      gap_q   <= gap_nx;
      len1_q  <= len1_nx;
      plen_q  <= plen_nx;
      short_q <= short_nx;
      long_q  <= long_nx;
      dbl_q   <= dbl_nx;
      perr_q  <= perr_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state;
    len_nx   = len_q;
    gap_nx   = gap_q;
    len1_nx  = len1_q;
    plen_nx  = plen_q;
    short_nx = 1'b0;
    long_nx  = 1'b0;
    dbl_nx   = 1'b0;
    perr_nx  = 1'b0;

    if (!bus.en) begin
      state_nx = IDLE;
      len_nx   = '0;
      gap_nx   = '0;
      len1_nx  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise_ok) begin
            state_nx = PRESS1;
            len_nx   = ONE_V;
          end else if (bus.down) begin
            perr_nx = 1'b1;
          end
        end

        PRESS1: begin
          len_nx = len_inc;
          if (down_ok) begin
            if (len_q >= LONG_V) begin
              long_nx  = 1'b1;
              plen_nx  = len_q;
              state_nx = IDLE;
            end else begin
              len1_nx  = len_q;
              gap_nx   = ONE_V;
              state_nx = GAP;
            end
          end else if (bus.rise) begin
            perr_nx = 1'b1;
          end
        end

        GAP: begin
          gap_nx = gap_inc;
          // A rise on the last allowed gap cycle still makes a double press.
          if (rise_ok && (gap_q <= GAP_V)) begin
            len_nx   = ONE_V;
            state_nx = PRESS2;
          end else begin
            perr_nx = bus.down;
            if (gap_q >= GAP_V) begin
              short_nx = 1'b1;
              plen_nx  = len1_q;
              state_nx = IDLE;
            end
          end
        end

        PRESS2: begin
          len_nx = len_inc;
          if (down_ok) begin
            dbl_nx   = 1'b1;
            plen_nx  = len_q;
            state_nx = IDLE;
          end else if (bus.rise) begin
            perr_nx = 1'b1;
          end
        end

        default: state_nx = IDLE;
      endcase
      if (both) perr_nx = 1'b1;
    end
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_press = dbl_q;
  assign bus.press_len    = plen_q;
  assign bus.proto_err    = perr_q;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_press_classify.sv
// Directed bench for press_classify (CNT_W=8, LONG_TH=8, DBL_GAP=4) with a
// timestamp-based reference model compared every cycle plus literal pins.
module tb_press_classify;

  localparam int CNT_W   = 8;
  localparam int LONG_TH = 8;
  localparam int DBL_GAP = 4;
  localparam int MAXV    = 255;
  localparam int LOGN    = 400;

  logic clk;
  logic rst_n;

  press_if #(.CNT_W(CNT_W)) bus ();

  press_classify #(.CNT_W(CNT_W), .LONG_TH(LONG_TH), .DBL_GAP(DBL_GAP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: press lengths and gaps are cycle-stamp differences.
  int   phase, t_rise, t_rel, first_len, gcyc;
  logic m_s, m_l, m_d, m_p, m_b;
  logic [CNT_W-1:0] m_len;

  // Per-test output logs indexed by the cycle the output is visible in.
  logic s_log [LOGN];
  logic l_log [LOGN];
  logic d_log [LOGN];
  logic p_log [LOGN];
  logic b_log [LOGN];
  int   len_log [LOGN];
  int   tcyc;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    phase = 0; m_s = 0; m_l = 0; m_d = 0; m_p = 0; m_b = 0; m_len = '0;
  endtask

  task automatic model_step(input logic e, input logic r, input logic d);
    int n, g;
    m_s = 0; m_l = 0; m_d = 0; m_p = 0;
    if (!e) begin
      phase = 0;
    end else begin
      case (phase)
        0: if (r && !d) begin phase = 1; t_rise = gcyc; end
           else if (d) m_p = 1;
        1: if (d && !r) begin
             n = gcyc - t_rise;
             if (n > MAXV) n = MAXV;
             if (n >= LONG_TH) begin m_l = 1; m_len = CNT_W'(n); phase = 0; end
             else begin first_len = n; t_rel = gcyc; phase = 2; end
           end else if (r) m_p = 1;
        2: begin
             g = gcyc - t_rel;
             if (r && !d && g <= DBL_GAP) begin phase = 3; t_rise = gcyc; end
             else begin
               if (d) m_p = 1;
               if (g >= DBL_GAP) begin m_s = 1; m_len = CNT_W'(first_len); phase = 0; end
             end
           end
        default: if (d && !r) begin
             n = gcyc - t_rise;
             if (n > MAXV) n = MAXV;
             m_d = 1; m_len = CNT_W'(n); phase = 0;
           end else if (r) m_p = 1;
      endcase
    end
    m_b = (phase != 0);
    gcyc++;
  endtask

  // One clock cycle: drive inputs, let the edge pass, compare against model.
  task automatic step(input logic e, input logic r, input logic d);
    logic [12:0] got, exp;
    @(negedge clk);
    bus.en = e; bus.rise = r; bus.down = d;
    @(posedge clk);
    #1;
    model_step(e, r, d);
    got = {bus.short_press, bus.long_press, bus.double_press, bus.proto_err,
           bus.busy, bus.press_len};
    exp = {m_s, m_l, m_d, m_p, m_b, m_len};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle_compare t=%0d: got s%b l%b d%b p%b b%b len%0d expected s%b l%b d%b p%b b%b len%0d",
               tcyc + 1, got[12], got[11], got[10], got[9], got[8], got[7:0],
               exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
    tcyc++;
    if (tcyc < LOGN) begin
      s_log[tcyc] = bus.short_press; l_log[tcyc] = bus.long_press;
      d_log[tcyc] = bus.double_press; p_log[tcyc] = bus.proto_err;
      b_log[tcyc] = bus.busy; len_log[tcyc] = int'(bus.press_len);
    end
  endtask

  task automatic clear_logs();
    tcyc = 0;
    for (int i = 0; i < LOGN; i++) begin
      s_log[i] = 0; l_log[i] = 0; d_log[i] = 0; p_log[i] = 0; b_log[i] = 0; len_log[i] = 0;
    end
  endtask

  function automatic int cnt(input int which);
    int c = 0;
    for (int i = 0; i < LOGN; i++) begin
      case (which)
        0: c += int'(s_log[i]);
        1: c += int'(l_log[i]);
        2: c += int'(d_log[i]);
        default: c += int'(p_log[i]);
      endcase
    end
    return c;
  endfunction

  task automatic run_seq(input int r1, input int d1, input int r2, input int d2, input int n);
    clear_logs();
    for (int c = 0; c < n; c++)
      step(1'b1, (c == r1) || (c == r2), (c == d1) || (c == d2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bus.en = 1'b0; bus.rise = 1'b0; bus.down = 1'b0;
    gcyc = 0; model_reset(); clear_logs();
    #23;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_len", int'(bus.press_len), 0);
    chk("reset_pulses", int'({bus.short_press, bus.long_press, bus.double_press, bus.proto_err}), 0);
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);

    // Short press.
    run_seq(10, 13, -1, -1, 25);
    chk("short_pulse@18", int'(s_log[18]), 1);
    chk("short_len", len_log[18], 3);
    chk("short_busy17", int'(b_log[17]), 1);
    chk("short_busy18", int'(b_log[18]), 0);
    chk("short_count", cnt(0), 1);

    // Long press.
    run_seq(10, 20, -1, -1, 30);
    chk("long_pulse@21", int'(l_log[21]), 1);
    chk("long_len", len_log[21], 10);
    chk("long_no_short", cnt(0), 0);

    // Double press, rise on the last gap cycle.
    run_seq(10, 12, 16, 19, 30);
    chk("dbl_pulse@20", int'(d_log[20]), 1);
    chk("dbl_len", len_log[20], 3);
    chk("dbl_no_short", cnt(0), 0);

    // Rise one cycle late: short, then a fresh press from idle.
    run_seq(10, 12, 17, 19, 30);
    chk("late_short@17", int'(s_log[17]), 1);
    chk("late_short_len", len_log[17], 2);
    chk("late_busy18", int'(b_log[18]), 1);
    chk("late_second_short@24", int'(s_log[24]), 1);
    chk("late_no_dbl", cnt(2), 0);

    // Long threshold boundary.
    run_seq(2, 10, -1, -1, 20);
    chk("len8_long@11", int'(l_log[11]), 1);
    chk("len8_len", len_log[11], 8);
    run_seq(2, 9, -1, -1, 20);
    chk("len7_short@14", int'(s_log[14]), 1);
    chk("len7_len", len_log[14], 7);

    // Long second press is still a double.
    run_seq(2, 4, 7, 17, 25);
    chk("dbl_long@18", int'(d_log[18]), 1);
    chk("dbl_long_len", len_log[18], 10);
    chk("dbl_long_no_long", cnt(1), 0);

    // Saturation.
    run_seq(10, 310, -1, -1, 320);
    chk("sat_long@311", int'(l_log[311]), 1);
    chk("sat_len", len_log[311], 255);

    // Rise while pressed is an error and the press continues.
    run_seq(2, 6, 4, -1, 20);
    chk("rise_in_press_err@5", int'(p_log[5]), 1);
    chk("rise_in_press_short@11", int'(s_log[11]), 1);
    chk("rise_in_press_len", len_log[11], 4);

    // Simultaneous rise and down in idle.
    run_seq(5, 5, -1, -1, 12);
    chk("both_err@6", int'(p_log[6]), 1);
    chk("both_idle", int'(b_log[6]), 0);

    // Reset in the middle of a press, then a stray release.
    run_seq(2, -1, -1, -1, 5);
    chk("pre_reset_busy", int'(bus.busy), 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset_busy", int'(bus.busy), 0);
    chk("async_reset_len", int'(bus.press_len), 0);
    @(negedge clk); rst_n = 1'b1;
    run_seq(-1, 3, -1, -1, 12);
    chk("post_reset_err@4", int'(p_log[4]), 1);
    chk("post_reset_events", cnt(0) + cnt(1) + cnt(2), 0);

    // Enable low aborts a press; press_len holds the last result.
    run_seq(2, 5, -1, -1, 14);
    chk("pre_en_short_len", len_log[10], 3);
    clear_logs();
    for (int c = 0; c < 14; c++)
      step(!(c == 5 || c == 6), c == 2, c == 8 || c == 6);
    chk("en_low_busy@6", int'(b_log[6]), 0);
    chk("en_low_len_hold", len_log[7], 3);
    chk("en_low_no_err@7", int'(p_log[7]), 0);
    chk("en_stray_down_err@9", int'(p_log[9]), 1);
    chk("en_no_events", cnt(0) + cnt(1) + cnt(2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
